spi_dac_receiver: RTL and testbench
===================================

Name: spi_dac_receiver

Overview:
- SPI slave/deserializer: the receiving end of the DAC SPI link; captures the 24-bit frames the DAC SPI transmitter sends (8-bit command + 16-bit value, MSB first).
- Used as the DAC-side model in DAC benches and as the on-chip loopback checker for DAC traffic.
- All SPI inputs are oversampled in the single FPGA clock domain. No SPI pin is used as a clock.

Parameters:
- FRAME_BITS, 24, bits per frame.
- CMD_BITS, 8, leading command bits. The value width is FRAME_BITS-CMD_BITS.
- SYNC_STAGES, 2, synchronizer flops per SPI input (minimum 2).

Ports:
- clock_in  input  1  FPGA clock; all logic rises on this edge.
- reset_n  input  1  asynchronous active-low reset.
- spi_cs_in  input  1  chip select, active-low.
- spi_clock_in  input  1  SPI clock, idle low (mode 0).
- spi_data_in  input  1  SPI data; sampled on the SCLK rising edge.
- data_out  output  FRAME_BITS  last complete frame.
- command_out  output  CMD_BITS  data_out[FRAME_BITS-1 -: CMD_BITS].
- value_out  output  FRAME_BITS-CMD_BITS  low bits of data_out.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_error  output  1  one-cycle pulse on a malformed frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset: data_out, command_out and value_out = 0; data_valid, frame_error and busy = 0; FSM = IDLE; bit counter = 0; synchronizers load idle levels (cs=1, sclk=0, data=0).
- Sync: each input passes through SYNC_STAGES flops, plus one history flop on cs and sclk for edge detection.
- Edges: sclk_rise = sync high and previous low. cs_fall and cs_rise are defined the same way.
- Timing: clock_in must be at least 4x the SPI clock. The transmitter's SCLK high and low phases are each at least 2 clock_in cycles.
- FSM IDLE: on cs_fall, clear the shift register and bit counter, set busy=1, go to SHIFT. SCLK edges are ignored in IDLE.
- FSM SHIFT, sclk_rise: shift_reg <= {shift_reg[FRAME_BITS-2:0], data_sync}; counter increments and saturates at FRAME_BITS+1.
- FSM SHIFT, cs_rise: go to END.
  - If counter == FRAME_BITS: data_out <= shift_reg and data_valid=1.
  - Otherwise frame_error=1 and data_out holds.
- Simultaneous sclk_rise and cs_rise in the same cycle: the bit is shifted and counted first, then the frame is evaluated.
- FSM END: busy=0, one cycle, then IDLE. A cs_fall seen in END is latched and starts the next frame on the following cycle, so back-to-back frames are not lost.
- Latency: data_valid asserts SYNC_STAGES+2 clock_in cycles after the CS rising edge at the pin.
- Output relation: command_out and value_out are combinational slices of the registered data_out.
- More than FRAME_BITS edges in one frame: error; the counter saturates.
- Zero edges (CS pulse only): error.
- Reset mid-frame: the frame is abandoned and the FSM returns to IDLE. If CS is still low at release, no frame starts until a fresh cs_fall.

Optional Feature:
- Macro: SPI_RX_ECHO_EN.
- Defined:
  - Adds output spi_echo_out (1 bit), which shifts out the previous valid frame MSB first for daisy-chain readback checks.
  - The frame is loaded at cs_fall.
  - The bit changes on each sclk_fall, with the MSB presented immediately after the load.
  - Driven 0 when CS is high. Reset value 0.
- Undefined: the port and its logic are absent. Port list and behaviour are otherwise identical.

Decomposition:
- Package spi_dac_pkg:
  - FSM state typedef (IDLE, SHIFT, END).
  - FRAME_BITS and CMD_BITS default constants.
  - Command-field constants shared with the DAC SPI transmitter, e.g. write-and-update = 8'b0011_0001.
- Sub-module spi_input_sync: one instance per SPI input. Parameterised depth; outputs the synchronized level plus rise/fall pulses.

Test Plan:
- Frame 0x31AACC, SCLK = clock_in/4 -> one data_valid pulse; command_out=0x31, value_out=0xAACC; frame_error stays 0.
- Back-to-back 0x31AACC then 0xB155CD, with CS high for 2 clock_in cycles between them -> two data_valid pulses in order; final value_out=0x55CD, command_out=0xB1.
- 23-bit frame, then a 25-bit frame -> frame_error pulses twice, no data_valid; data_out keeps 0x31AACC from the previous frame.
- reset_n low after 12 bits of 0xB155CD, released with CS low, then a full frame 0x123456 -> no output for the aborted frame; data_valid pulses with data_out=0x123456.
- SCLK toggling while CS is high -> no busy, no data_valid, no frame_error.
- SPI_RX_ECHO_EN defined: receive 0x31AACC, then send a second frame -> spi_echo_out serially reproduces 0x31AACC MSB first, and reads 0 when CS is high.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the DAC SPI link.
// Command codes match the DAC SPI transmitter.
package spi_dac_pkg;

  localparam int DEF_FRAME_BITS = 24;
  localparam int DEF_CMD_BITS   = 8;

  localparam logic [7:0] CMD_NOP          = 8'b0000_0000;
  localparam logic [7:0] CMD_WRITE        = 8'b0001_0000;
  localparam logic [7:0] CMD_UPDATE       = 8'b0010_0000;
  localparam logic [7:0] CMD_WRITE_UPDATE = 8'b0011_0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END
  } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizer for one SPI pin with registered edge pulses.
// level, rise and fall are aligned to the same clock cycle.
module spi_input_sync #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{IDLE}};
      level <= IDLE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_dac_receiver.sv
// SPI mode-0 frame receiver for the DAC link, oversampled on clock_in.
// Optional SPI_RX_ECHO_EN adds spi_echo_out readback of the prior frame.
module spi_dac_receiver
  import spi_dac_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int CMD_BITS    = DEF_CMD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clock_in,
  input  logic                       reset_n,
  input  logic                       spi_cs_in,
  input  logic                       spi_clock_in,
  input  logic                       spi_data_in,
  output logic [FRAME_BITS-1:0]      data_out,
  output logic [CMD_BITS-1:0]        command_out,
  output logic [FRAME_BITS-CMD_BITS-1:0] value_out,
  output logic                       data_valid,
  output logic                       frame_error,
  output logic                       busy
`ifdef SPI_RX_ECHO_EN
  ,
  output logic                       spi_echo_out
`endif
);

  localparam int CW     = $clog2(FRAME_BITS + 2);
  localparam int SETTLE = SYNC_STAGES + 2;
  localparam int SW     = $clog2(SETTLE + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sd_lvl, sd_rise, sd_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs (
    .clock_in(clock_in), .reset_n(reset_n), .pin(spi_cs_in),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sck (
    .clock_in(clock_in), .reset_n(reset_n), .pin(spi_clock_in),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sd (
    .clock_in(clock_in), .reset_n(reset_n), .pin(spi_data_in),
    .level(sd_lvl), .rise(sd_rise), .fall(sd_fall)
  );

  logic unused_sig;
  assign unused_sig = ^{sck_lvl, sck_fall, sd_rise, sd_fall};

  state_t                state;
  logic [FRAME_BITS-1:0] shreg, sh_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [SW-1:0]         settle;
  logic                  settled, pend;

  assign settled = (settle == SW'(SETTLE));

  always_comb begin
    sh_nx  = shreg;
    cnt_nx = cnt;
    if (sck_rise) begin
      sh_nx = {shreg[FRAME_BITS-2:0], sd_lvl};
      if (cnt != CW'(FRAME_BITS + 1)) cnt_nx = cnt + 1'b1;
    end
  end

  // A CS already low at reset release must not look like a fresh frame.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      cnt         <= '0;
      settle      <= '0;
      pend        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (!settled) settle <= settle + 1'b1;
      unique case (state)
        ST_IDLE: begin
          if ((cs_fall || pend) && settled) begin
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            pend  <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= sh_nx;
          cnt   <= cnt_nx;
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= ST_END;
            if (cnt_nx == CW'(FRAME_BITS)) begin
              data_out   <= sh_nx;
              data_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        ST_END: begin
          pend  <= cs_fall;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign command_out = data_out[FRAME_BITS-1 -: CMD_BITS];
  assign value_out   = data_out[FRAME_BITS-CMD_BITS-1:0];

`ifdef SPI_RX_ECHO_EN
  logic [FRAME_BITS-1:0] echo_sh;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      echo_sh      <= '0;
      spi_echo_out <= 1'b0;
    end else if (cs_fall) begin
      spi_echo_out <= data_out[FRAME_BITS-1];
      echo_sh      <= {data_out[FRAME_BITS-2:0], 1'b0};
    end else if (cs_lvl) begin
      spi_echo_out <= 1'b0;
    end else if (sck_fall) begin
      spi_echo_out <= echo_sh[FRAME_BITS-1];
      echo_sh      <= {echo_sh[FRAME_BITS-2:0], 1'b0};
    end
  end
`endif

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Self-checking bench for spi_dac_receiver.
// Frame vectors feed a scoreboard checked on every output pulse.
module tb_spi_dac_receiver;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        spi_cs_in = 1'b1;
  logic        spi_clock_in = 1'b0;
  logic        spi_data_in = 1'b0;
  logic [23:0] data_out;
  logic [7:0]  command_out;
  logic [15:0] value_out;
  logic        data_valid;
  logic        frame_error;
  logic        busy;
  logic        echo_sig;

  always #5 clock_in = ~clock_in;

`ifdef SPI_RX_ECHO_EN
  logic spi_echo_out;
  assign echo_sig = spi_echo_out;
`else
  assign echo_sig = 1'b0;
`endif

  spi_dac_receiver dut (
    .clock_in(clock_in),
    .reset_n(reset_n),
    .spi_cs_in(spi_cs_in),
    .spi_clock_in(spi_clock_in),
    .spi_data_in(spi_data_in),
    .data_out(data_out),
    .command_out(command_out),
    .value_out(value_out),
    .data_valid(data_valid),
    .frame_error(frame_error),
    .busy(busy)
`ifdef SPI_RX_ECHO_EN
    ,
    .spi_echo_out(spi_echo_out)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    bit          ok;
    logic [23:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] exp_last = '0;

  task automatic push(input bit ok, input logic [23:0] d);
    exp_t e;
    if (ok) exp_last = d;
    e.ok   = ok;
    e.data = exp_last;
    sb.push_back(e);
  endtask

  always @(negedge clock_in) begin
    if (reset_n && (data_valid || frame_error)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse",
              {30'd0, data_valid, frame_error}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", {31'd0, data_valid}, {31'd0, e.ok});
        check("data_out", {8'd0, data_out}, {8'd0, e.data});
        if (e.ok) begin
          check("command_out", {24'd0, command_out},
                {24'd0, e.data[23:16]});
          check("value_out", {16'd0, value_out},
                {16'd0, e.data[15:0]});
        end
      end
    end
  end

  task automatic send_body(input int n,
                           input logic [31:0] bits,
                           input int half,
                           output logic [31:0] echo);
    echo = '0;
    spi_clock_in = 1'b0;
    spi_cs_in = 1'b0;
    repeat (half) @(negedge clock_in);
    for (int i = n - 1; i >= 0; i--) begin
      spi_data_in = bits[i];
      repeat (half) @(negedge clock_in);
      spi_clock_in = 1'b1;
      repeat (half) @(negedge clock_in);
      echo = {echo[30:0], echo_sig};
      spi_clock_in = 1'b0;
    end
    repeat (half) @(negedge clock_in);
  endtask

  task automatic end_frame();
    spi_cs_in = 1'b1;
    repeat (2) @(negedge clock_in);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++)
      @(negedge clock_in);
    check(name, sb.size(), 0);
  endtask

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    bit          ok;
    bit          wait_done;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] ecap;
  int          busy_hits;

  initial begin
    vecs[0] = '{24, 32'h0031AACC, 1'b1, 1'b1};
    vecs[1] = '{23, 32'h002AAAAA, 1'b0, 1'b1};
    vecs[2] = '{25, 32'h01ABCDEF, 1'b0, 1'b1};
    vecs[3] = '{0,  32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{24, 32'h0031AACC, 1'b1, 1'b0};
    vecs[5] = '{24, 32'h00B155CD, 1'b1, 1'b1};

    repeat (3) @(negedge clock_in);
    check("rst_data", {8'd0, data_out}, 32'd0);
    check("rst_cmd", {24'd0, command_out}, 32'd0);
    check("rst_val", {16'd0, value_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_err", {31'd0, frame_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clock_in);

    for (int v = 0; v < 6; v++) begin
      push(vecs[v].ok, vecs[v].bits[23:0]);
      send_body(vecs[v].nbits, vecs[v].bits, 2, ecap);
      end_frame();
      if (vecs[v].wait_done) drain("drain_vec");
    end
    check("final_cmd", {24'd0, command_out}, 32'h000000B1);
    check("final_val", {16'd0, value_out}, 32'h000055CD);

    push(1'b1, 24'h31AACC);
    send_body(24, 32'h0031AACC, 2, ecap);
    spi_cs_in = 1'b1;
    repeat (3) @(negedge clock_in);
    check("lat_early", {31'd0, data_valid}, 32'd0);
    @(negedge clock_in);
    check("lat_edge", {31'd0, data_valid}, 32'd1);
    drain("drain_lat");

    send_body(12, 32'h00000B15, 2, ecap);
    check("busy_mid", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    spi_clock_in = 1'b0;
    repeat (3) @(negedge clock_in);
    check("rst2_data", {8'd0, data_out}, 32'd0);
    exp_last = '0;
    reset_n = 1'b1;
    busy_hits = 0;
    repeat (12) begin
      @(negedge clock_in);
      if (busy) busy_hits++;
    end
    check("no_start_cs_low", busy_hits, 0);
    end_frame();
    push(1'b1, 24'h123456);
    send_body(24, 32'h00123456, 2, ecap);
    end_frame();
    drain("drain_abort");

    busy_hits = 0;
    for (int i = 0; i < 20; i++) begin
      spi_clock_in = ~spi_clock_in;
      spi_data_in = i[0];
      repeat (2) @(negedge clock_in);
      if (busy) busy_hits++;
    end
    spi_clock_in = 1'b0;
    repeat (6) @(negedge clock_in);
    check("sclk_cs_high_busy", busy_hits, 0);
    check("sclk_cs_high_q", sb.size(), 0);

`ifdef SPI_RX_ECHO_EN
    check("echo_idle0", {31'd0, echo_sig}, 32'd0);
    push(1'b1, 24'h31AACC);
    send_body(24, 32'h0031AACC, 4, ecap);
    end_frame();
    drain("drain_echo1");
    check("echo_idle1", {31'd0, echo_sig}, 32'd0);
    push(1'b1, 24'h00FF00);
    send_body(24, 32'h0000FF00, 4, ecap);
    end_frame();
    check("echo_bits", {8'd0, ecap[23:0]}, 32'h0031AACC);
    drain("drain_echo2");
    repeat (4) @(negedge clock_in);
    check("echo_idle2", {31'd0, echo_sig}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
